// File: rtl/debug_action_pkg.sv
// Shared defaults, command entry layout and channel decode for the debug action synchronizer.
package debug_action_pkg;

  localparam int unsigned DefDataW  = 38;
  localparam int unsigned DefIrW    = 2;
  localparam int unsigned DefActBit = 35;

  // Command entry layout at the default widths; ir sits above data when packed.
  typedef struct packed {
    logic [DefIrW-1:0]   ir;
    logic [DefDataW-1:0] data;
  } cmd_entry_t;

  // One bit of a one-hot channel decode: set when pos is the selected channel.
  function automatic logic onehot_bit(input int unsigned idx, input int unsigned pos);
    return idx == pos;
  endfunction

endpackage

// File: rtl/debug_cmd_fifo.sv
// Register-based synchronous command FIFO with occupancy level; no read bypass.
module debug_cmd_fifo #(
  parameter int unsigned Width = 40,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [Width-1:0]           wdata_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = $clog2(Depth+1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rptr_q];

  // A push into a full FIFO is only accepted when a pop frees a slot on the same edge.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) wptr_d = wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = rptr_q + PtrW'(1);
    if (do_push && !do_pop) begin
      level_d = level_q + LvlW'(1);
    end else if (!do_push && do_pop) begin
      level_d = level_q - LvlW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/debug_action_sync.sv
// TCK-to-clk command synchronizer and action decoder for the debug module.
// Define DBG_OVERRUN_CNT_EN to build the saturating dropped-capture counter.
module debug_action_sync
  import debug_action_pkg::*;
#(
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned IR_W        = DefIrW,
  parameter int unsigned ACT_BIT     = DefActBit,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              vs_udr,
  input  logic                              vs_uir,
  input  logic [IR_W-1:0]                   ir_in,
  input  logic [DATA_W-1:0]                 sr,
  input  logic                              action_ready,
  input  logic                              overrun_clr,
  output logic [DATA_W-1:0]                 jdo,
  output logic [IR_W-1:0]                   jdo_ir,
  output logic [2**IR_W-1:0]                take_action,
  output logic [2**IR_W-1:0]                take_no_action,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              overrun,
  output logic [7:0]                        overrun_count
);

  localparam int unsigned Nch    = 2**IR_W;
  localparam int unsigned EntryW = IR_W + DATA_W;

  typedef struct packed {
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] data;
  } cmd_t;

  logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
  logic                   udr_hist_q, uir_hist_q;
  logic                   udr_edge, uir_edge;

  logic [IR_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0] jdo_q, jdo_d;
  logic [IR_W-1:0]   jdo_ir_q, jdo_ir_d;
  logic [Nch-1:0]    act_q, act_d;
  logic [Nch-1:0]    noact_q, noact_d;
  logic [Nch-1:0]    dec;
  logic              overrun_q, overrun_d;

  cmd_t wr_cmd, rd_cmd;
  logic fifo_full, fifo_empty, pop, drop;

  // One edge per strobe no matter how long it stays high.
  assign udr_edge = udr_sync_q[SYNC_STAGES-1] & ~udr_hist_q;
  assign uir_edge = uir_sync_q[SYNC_STAGES-1] & ~uir_hist_q;

  assign pop  = action_ready & ~fifo_empty;
  assign drop = udr_edge & fifo_full & ~pop;

  always_comb begin
    ir_d = uir_edge ? ir_in : ir_q;
    // Coincident IR and DR updates must tag the entry with the new instruction.
    wr_cmd.ir   = ir_d;
    wr_cmd.data = sr;
  end

  debug_cmd_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (udr_edge),
    .pop_i   (pop),
    .wdata_i (wr_cmd),
    .rdata_o (rd_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    dec = '0;
    for (int i = 0; i < Nch; i++) begin
      dec[i] = onehot_bit(32'(rd_cmd.ir), i);
    end
  end

  always_comb begin
    jdo_d    = jdo_q;
    jdo_ir_d = jdo_ir_q;
    act_d    = '0;
    noact_d  = '0;
    if (pop) begin
      jdo_d    = rd_cmd.data;
      jdo_ir_d = rd_cmd.ir;
      if (rd_cmd.data[ACT_BIT]) begin
        act_d = dec;
      end else begin
        noact_d = dec;
      end
    end
  end

  always_comb begin
    overrun_d = overrun_q;
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end else if (drop) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      udr_sync_q <= '0;
      uir_sync_q <= '0;
      udr_hist_q <= 1'b0;
      uir_hist_q <= 1'b0;
      ir_q       <= '0;
      jdo_q      <= '0;
      jdo_ir_q   <= '0;
      act_q      <= '0;
      noact_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_hist_q <= udr_sync_q[SYNC_STAGES-1];
      uir_hist_q <= uir_sync_q[SYNC_STAGES-1];
      ir_q       <= ir_d;
      jdo_q      <= jdo_d;
      jdo_ir_q   <= jdo_ir_d;
      act_q      <= act_d;
      noact_q    <= noact_d;
      overrun_q  <= overrun_d;
    end
  end

`ifdef DBG_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (overrun_clr) begin
      ovr_cnt_d = 8'd0;
    end else if (drop && (ovr_cnt_q != 8'hff)) begin
      ovr_cnt_d = ovr_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_cnt_q <= 8'd0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign overrun_count = ovr_cnt_q;
`else
  assign overrun_count = 8'd0;
`endif

  assign jdo            = jdo_q;
  assign jdo_ir         = jdo_ir_q;
  assign take_action    = act_q;
  assign take_no_action = noact_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_debug_action_sync.sv
// Directed self-checking bench for debug_action_sync at default parameters.
module tb_debug_action_sync;

  localparam int unsigned DW  = 38;
  localparam int unsigned IW  = 2;
  localparam int unsigned NCH = 4;
  localparam int unsigned LW  = 3;

  logic          clk = 1'b0;
  logic          reset, vs_udr, vs_uir, action_ready, overrun_clr;
  logic [IW-1:0] ir_in;
  logic [DW-1:0] sr;
  logic [DW-1:0] jdo;
  logic [IW-1:0] jdo_ir;
  logic [NCH-1:0] take_action, take_no_action;
  logic [LW-1:0] fifo_level;
  logic          overrun;
  logic [7:0]    overrun_count;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_cnt;

  always #5 clk = ~clk;

  debug_action_sync dut (
    .clk            (clk),
    .reset          (reset),
    .vs_udr         (vs_udr),
    .vs_uir         (vs_uir),
    .ir_in          (ir_in),
    .sr             (sr),
    .action_ready   (action_ready),
    .overrun_clr    (overrun_clr),
    .jdo            (jdo),
    .jdo_ir         (jdo_ir),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .fifo_level     (fifo_level),
    .overrun        (overrun),
    .overrun_count  (overrun_count)
  );

  // One-cycle strobe followed by three low cycles; returns #1 after the third edge.
  task automatic strobe(input logic u, input logic d);
    vs_uir = u;
    vs_udr = d;
    @(posedge clk);
    #1;
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (jdo !== '0) begin bad++; $display("FAIL reset_jdo: got %h want 0", jdo); end
    total++; if (jdo_ir !== '0) begin bad++; $display("FAIL reset_jdo_ir: got %h want 0", jdo_ir); end
    total++; if (take_action !== '0) begin bad++; $display("FAIL reset_act: got %b want 0", take_action); end
    total++; if (take_no_action !== '0) begin bad++; $display("FAIL reset_noact: got %b want 0", take_no_action); end
    total++; if (fifo_level !== '0) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    total++; if (overrun_count !== 8'd0) begin bad++; $display("FAIL reset_ovr_cnt: got %0d want 0", overrun_count); end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_action_latency();
    ir_in = 2'd2;
    strobe(1'b1, 1'b0);
    sr = 38'h8_0000_1234;
    action_ready = 1'b1;
    vs_udr = 1'b1;
    @(posedge clk); #1;  // E0
    vs_udr = 1'b0;
    @(posedge clk); #1;  // E1
    total++; if (take_action !== 4'b0000) begin bad++; $display("FAIL lat_e1_act: got %b want 0000", take_action); end
    @(posedge clk); #1;  // E2: push
    total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL lat_e2_level: got %0d want 1", fifo_level); end
    total++; if (take_action !== 4'b0000) begin bad++; $display("FAIL lat_e2_act: got %b want 0000", take_action); end
    @(posedge clk); #1;  // E3: pop
    total++; if (take_action !== 4'b0100) begin bad++; $display("FAIL lat_e3_act: got %b want 0100", take_action); end
    total++; if (take_no_action !== 4'b0000) begin bad++; $display("FAIL lat_e3_noact: got %b want 0000", take_no_action); end
    total++; if (jdo !== 38'h8_0000_1234) begin bad++; $display("FAIL lat_jdo: got %h want 8000001234", jdo); end
    total++; if (jdo_ir !== 2'd2) begin bad++; $display("FAIL lat_jdo_ir: got %0d want 2", jdo_ir); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL lat_e3_level: got %0d want 0", fifo_level); end
    @(posedge clk); #1;  // E4
    total++; if (take_action !== 4'b0000) begin bad++; $display("FAIL lat_e4_act: got %b want 0000", take_action); end
    total++; if (jdo !== 38'h8_0000_1234) begin bad++; $display("FAIL lat_jdo_hold: got %h want 8000001234", jdo); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_no_action();
    sr = 38'h0_0000_5678;
    vs_udr = 1'b1;
    @(posedge clk); #1;
    vs_udr = 1'b0;
    repeat (3) @(posedge clk);
    #1;  // E3
    total++; if (take_no_action !== 4'b0100) begin bad++; $display("FAIL noact_pulse: got %b want 0100", take_no_action); end
    total++; if (take_action !== 4'b0000) begin bad++; $display("FAIL noact_act: got %b want 0000", take_action); end
    total++; if (jdo !== 38'h0_0000_5678) begin bad++; $display("FAIL noact_jdo: got %h want 0000005678", jdo); end
    @(posedge clk); #1;
    total++; if (take_no_action !== 4'b0000) begin bad++; $display("FAIL noact_width: got %b want 0000", take_no_action); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] bp_ir [5];
    logic          bp_act [5];
    logic [DW-1:0] bp_data [5];
    logic [NCH-1:0] exp_a, exp_n;
    bp_ir  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    bp_act = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      bp_data[i]     = DW'(32'h100 + i);
      bp_data[i][35] = bp_act[i];
    end
    action_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ir_in = bp_ir[i];
      sr    = bp_data[i];
      strobe(1'b1, 1'b1);  // IR and DR updates land on the same cycle
    end
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL bp_level: got %0d want 4", fifo_level); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun: got %b want 1", overrun); end
    total++; if (overrun_count !== exp_cnt) begin bad++; $display("FAIL bp_ovr_cnt: got %0d want %0d", overrun_count, exp_cnt); end
    action_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      exp_a = bp_act[k] ? (4'b0001 << bp_ir[k]) : 4'b0000;
      exp_n = bp_act[k] ? 4'b0000 : (4'b0001 << bp_ir[k]);
      total++; if (take_action !== exp_a) begin bad++; $display("FAIL bp_drain_act[%0d]: got %b want %b", k, take_action, exp_a); end
      total++; if (take_no_action !== exp_n) begin bad++; $display("FAIL bp_drain_noact[%0d]: got %b want %b", k, take_no_action, exp_n); end
      total++; if (jdo !== bp_data[k]) begin bad++; $display("FAIL bp_drain_jdo[%0d]: got %h want %h", k, jdo, bp_data[k]); end
      total++; if (jdo_ir !== bp_ir[k]) begin bad++; $display("FAIL bp_drain_ir[%0d]: got %0d want %0d", k, jdo_ir, bp_ir[k]); end
    end
    @(posedge clk); #1;
    total++; if ((take_action | take_no_action) !== 4'b0000) begin bad++; $display("FAIL bp_after_drain: got %b want 0000", take_action | take_no_action); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL bp_empty: got %0d want 0", fifo_level); end
    action_ready = 1'b0;
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL clr_overrun: got %b want 0", overrun); end
    total++; if (overrun_count !== 8'd0) begin bad++; $display("FAIL clr_ovr_cnt: got %0d want 0", overrun_count); end
  endtask

  task automatic test_push_pop_full();
    logic [DW-1:0] ff_data [5];
    for (int i = 0; i < 5; i++) begin
      ff_data[i]     = DW'(32'hA0 + i);
      ff_data[i][35] = 1'b1;
    end
    action_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sr = ff_data[i];
      strobe(1'b0, 1'b1);
    end
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL ppf_fill: got %0d want 4", fifo_level); end
    sr = ff_data[4];
    vs_udr = 1'b1;
    @(posedge clk); #1;  // E0
    vs_udr = 1'b0;
    @(posedge clk); #1;  // E1
    action_ready = 1'b1;
    @(posedge clk); #1;  // E2: push and pop together
    action_ready = 1'b0;
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL ppf_level: got %0d want 4", fifo_level); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ppf_overrun: got %b want 0", overrun); end
    total++; if (take_action !== 4'b0001) begin bad++; $display("FAIL ppf_act: got %b want 0001", take_action); end
    total++; if (jdo !== ff_data[0]) begin bad++; $display("FAIL ppf_jdo: got %h want %h", jdo, ff_data[0]); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL ppf_level_hold: got %0d want 4", fifo_level); end
    action_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    action_ready = 1'b0;
    total++; if (jdo !== ff_data[4]) begin bad++; $display("FAIL ppf_last_jdo: got %h want %h", jdo, ff_data[4]); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL ppf_drained: got %0d want 0", fifo_level); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic seen;
    logic [DW-1:0] d;
    action_ready = 1'b0;
    ir_in = 2'd3;
    for (int i = 0; i < 3; i++) begin
      sr = DW'(32'hC0 + i);
      strobe(1'b1, 1'b1);
    end
    total++; if (fifo_level !== 3'd3) begin bad++; $display("FAIL rm_queued: got %0d want 3", fifo_level); end
    vs_udr = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rm_level: got %0d want 0", fifo_level); end
    total++; if (jdo !== '0) begin bad++; $display("FAIL rm_jdo: got %h want 0", jdo); end
    total++; if (jdo_ir !== '0) begin bad++; $display("FAIL rm_jdo_ir: got %0d want 0", jdo_ir); end
    reset = 1'b0;
    vs_udr = 1'b0;
    action_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if ((take_action | take_no_action) != '0 || fifo_level != '0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rm_quiet: got activity=%b want 0", seen); end
    d = 38'h8_0000_00EE;
    sr = d;
    strobe(1'b0, 1'b1);  // ir_q was cleared by reset, so channel 0
    total++; if (take_action !== 4'b0001) begin bad++; $display("FAIL rm_new_act: got %b want 0001", take_action); end
    total++; if (jdo_ir !== 2'd0) begin bad++; $display("FAIL rm_new_ir: got %0d want 0", jdo_ir); end
    total++; if (jdo !== d) begin bad++; $display("FAIL rm_new_jdo: got %h want %h", jdo, d); end
    action_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_strobe_length();
    logic [DW-1:0] d;
    d = 38'h0_0000_0777;
    action_ready = 1'b0;
    sr = d;
    vs_udr = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    vs_udr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL len_pushes: got %0d want 1", fifo_level); end
    action_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (take_no_action !== 4'b0001) begin bad++; $display("FAIL len_noact: got %b want 0001", take_no_action); end
    total++; if (jdo !== d) begin bad++; $display("FAIL len_jdo: got %h want %h", jdo, d); end
    @(posedge clk); #1;
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL len_empty: got %0d want 0", fifo_level); end
    action_ready = 1'b0;
  endtask

  initial begin
`ifdef DBG_OVERRUN_CNT_EN
    exp_cnt = 8'd1;
`else
    exp_cnt = 8'd0;
`endif
    reset        = 1'b1;
    vs_udr       = 1'b0;
    vs_uir       = 1'b0;
    ir_in        = '0;
    sr           = '0;
    action_ready = 1'b0;
    overrun_clr  = 1'b0;
    test_reset();
    test_action_latency();
    test_no_action();
    test_backpressure();
    test_push_pop_full();
    test_reset_mid();
    test_strobe_length();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
